// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: pairs a single operand word stream into (a, b)
// pairs, buffers them in a FIFO and serves gcd_top's two operand channels.
module gcd_operand_feeder #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clockInput,
  input  logic                 resetInput,
  input  logic                 flushInput,
  input  logic                 wInIsReadyInput,
  input  logic [WIDTH-1:0]     wInDataInput,
  output logic                 wInAckOutput,
  output logic                 aOutReadyOutput,
  output logic [WIDTH-1:0]     aOutDataOutput,
  input  logic                 aOutAckInput,
  output logic                 bOutReadyOutput,
  output logic [WIDTH-1:0]     bOutDataOutput,
  input  logic                 bOutAckInput,
  output logic [CNT_WIDTH-1:0] pairCountOutput,
  output logic                 heldValidOutput
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_ACK,
    IN_COOL
  } inState_t;

  inState_t inState;
  inState_t inStateNext;

  logic             capture;
  logic [WIDTH-1:0] heldWord;
  logic             heldValid;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;
  logic [PW:0]        count;

  logic notEmpty;
  logic full;
  logic push;
  logic pop;
  logic aDone;
  logic bDone;
  logic outCool;
  logic aFire;
  logic bFire;

  assign notEmpty = (count != '0);
  assign full     = (count == (PW+1)'(DEPTH));

  assign aOutReadyOutput = notEmpty && !aDone && !outCool;
  assign bOutReadyOutput = notEmpty && !bDone && !outCool;
  assign aFire = aOutReadyOutput && aOutAckInput;
  assign bFire = bOutReadyOutput && bOutAckInput;

  assign pop  = (aDone || aFire) && (bDone || bFire) && !flushInput;
  assign push = capture && heldValid && !flushInput;

  assign aOutDataOutput = notEmpty ? mem[rdPtr][2*WIDTH-1:WIDTH] : '0;
  assign bOutDataOutput = notEmpty ? mem[rdPtr][WIDTH-1:0] : '0;

  assign wInAckOutput    = (inState == IN_ACK);
  assign heldValidOutput = heldValid;

  // Input handshake state register
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) inState <= IN_IDLE;
    else            inState <= inStateNext;
  end

  // Input FSM: capture when a slot exists (full sampled before any pop)
  always_comb begin
    inStateNext = inState;
    capture     = 1'b0;
    unique case (inState)
      IN_IDLE: begin
        if (wInIsReadyInput && (!heldValid || !full)) begin
          capture     = 1'b1;
          inStateNext = IN_ACK;
        end
      end
      IN_ACK:  inStateNext = IN_COOL;
      IN_COOL: inStateNext = IN_IDLE;
      default: inStateNext = IN_IDLE;
    endcase
  end

  // Odd word holding register
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) begin
      heldWord  <= '0;
      heldValid <= 1'b0;
    end else if (flushInput) begin
      heldValid <= 1'b0;
    end else if (capture) begin
      if (!heldValid) begin
        heldWord  <= wInDataInput;
        heldValid <= 1'b1;
      end else begin
        heldValid <= 1'b0;
      end
    end
  end

  // Pair storage; head validity is tracked by count
  always_ff @(posedge clockInput) begin
    if (push) mem[wrPtr] <= {heldWord, wInDataInput};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flushInput) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output channel progress, cooldown and delivered-pair count
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) begin
      aDone           <= 1'b0;
      bDone           <= 1'b0;
      outCool         <= 1'b0;
      pairCountOutput <= '0;
    end else begin
      outCool <= pop;
      if (flushInput || pop) begin
        aDone <= 1'b0;
        bDone <= 1'b0;
      end else begin
        aDone <= aDone || aFire;
        bDone <= bDone || bFire;
      end
      if (pop) pairCountOutput <= pairCountOutput + CNT_WIDTH'(1);
    end
  end

endmodule
